// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run sequencer: state encoding,
// reset-vector constants and small state-decode helpers used by the
// registered output logic.
package cpu_run_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_RD,
    ST_CAP,
    ST_OUT,
    ST_DONE
  } state_t;

  // Wide enough for any sensible reset fan-out; the top slices NUM_RST bits.
  localparam int RST_MAX = 64;
  localparam logic [RST_MAX-1:0] RST_ALL  = {RST_MAX{1'b1}};
  localparam logic [RST_MAX-1:0] RST_NONE = {RST_MAX{1'b0}};

  // CPU blocks are held in reset while idle and during the reset window.
  function automatic logic holds_reset(input state_t s);
    return s inside {ST_IDLE, ST_RESET};
  endfunction

  // Instruction fetch is only useful while the program can execute.
  function automatic logic im_on(input state_t s);
    return s inside {ST_RESET, ST_RUN};
  endfunction

  // Data memory stays live through drain and dump so writeback lands and can be read.
  function automatic logic dm_on(input state_t s);
    return s inside {ST_RESET, ST_RUN, ST_DRAIN, ST_RD, ST_CAP, ST_OUT};
  endfunction

  function automatic logic is_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_DONE});
  endfunction

endpackage

// File: rtl/cpu_run_if.sv
// Bundle for the data-memory debug-read port and the dump stream.
//
// Handshake: a dump word transfers on a rising edge where dump_valid and
// dump_ready are both high. Once dump_valid rises, dump_addr/dump_data/
// dump_last hold stable until that transfer; dump_valid never depends
// combinationally on dump_ready, so the sink may tie dump_ready high.
// dm_rd_data is expected exactly one cycle after a dm_rd_en strobe.
interface cpu_run_if #(
  parameter int DM_AW  = 9,
  parameter int DATA_W = 32
);
  logic              dm_rd_en;
  logic [DM_AW-1:0]  dm_rd_addr;
  logic [DATA_W-1:0] dm_rd_data;

  logic              dump_valid;
  logic              dump_ready;
  logic [DM_AW-1:0]  dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dm_rd_en, dm_rd_addr,
    input  dm_rd_data,
    output dump_valid, dump_addr, dump_data, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dm_rd_en, dm_rd_addr,
    output dm_rd_data,
    input  dump_valid, dump_addr, dump_data, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/sat_counter.sv
// Loadable up/down counter that clamps at zero and at all-ones instead of
// wrapping. Load has priority over decrement, decrement over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count register with saturation at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      if (count != '0) count <= count - W'(1);
    end else if (inc) begin
      if (count != CNT_MAX) count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run sequencer for the pipelined CPU: holds the CPU in reset, releases it,
// runs until end_program or timeout, lets the pipeline drain, then streams
// every data-memory word out over the dump port. All outputs are registered
// from the next state so they change cleanly on the clock edge.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int NUM_RST      = 11,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 5,
  parameter int TIMEOUT      = 4096,
  parameter int CYC_W        = 32,
  parameter int DM_DEPTH     = 512,
  parameter int DM_AW        = 9,
  parameter int DATA_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               end_program,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ins_en,
  output logic               dm_en,
  cpu_run_if.master          bus,
  output logic [CYC_W-1:0]   cycle_count,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output state_t             state_dbg
);

  localparam int PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);

  localparam logic [DM_AW-1:0] LAST_ADDR    = DM_AW'(DM_DEPTH - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);
  localparam bit               TIMEOUT_ON   = (TIMEOUT != 0);

  state_t state, state_next;

  logic [PH_W-1:0] ph_cnt;
  logic [PH_W-1:0] ph_val;
  logic            ph_load, ph_dec;
  logic            cyc_clr, cyc_inc;
  logic            to_set, to_clr;
  logic            addr_clr, addr_inc, cap_en;

  logic [DM_AW-1:0]  rd_addr;
  logic              rd_en_q;
  logic              dump_valid_q;
  logic [DM_AW-1:0]  dump_addr_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              dump_last_q;

  // Phase counter: reset-window length, then drain length.
  sat_counter #(.W(PH_W)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .inc      (1'b0),
    .count    (ph_cnt)
  );

  // Run-cycle counter, frozen outside RUN and saturating at all-ones.
  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cyc_clr),
    .load_val ({CYC_W{1'b0}}),
    .dec      (1'b0),
    .inc      (cyc_inc),
    .count    (cycle_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the one-cycle control strobes for counters/datapath.
  always_comb begin
    state_next = state;
    ph_load    = 1'b0;
    ph_val     = '0;
    ph_dec     = 1'b0;
    cyc_clr    = 1'b0;
    cyc_inc    = 1'b0;
    to_set     = 1'b0;
    to_clr     = 1'b0;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    cap_en     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_RESET;
          ph_load    = 1'b1;
          ph_val     = PH_W'(RST_CYCLES);
          cyc_clr    = 1'b1;
          to_clr     = 1'b1;
          addr_clr   = 1'b1;
        end
      end
      ST_RESET: begin
        if (ph_cnt <= PH_W'(1)) state_next = ST_RUN;
        else                    ph_dec     = 1'b1;
      end
      ST_RUN: begin
        // end_program is checked first so a simultaneous timeout is not flagged.
        if (end_program) begin
          state_next = ST_DRAIN;
          ph_load    = 1'b1;
          ph_val     = PH_W'(DRAIN_CYCLES);
        end else if (TIMEOUT_ON && (cycle_count == TIMEOUT_LAST)) begin
          state_next = ST_DRAIN;
          ph_load    = 1'b1;
          ph_val     = PH_W'(DRAIN_CYCLES);
          to_set     = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        // A zero drain length still spends one cycle here.
        if (ph_cnt <= PH_W'(1)) state_next = ST_RD;
        else                    ph_dec     = 1'b1;
      end
      ST_RD: begin
        state_next = ST_CAP;
      end
      ST_CAP: begin
        state_next = ST_OUT;
        cap_en     = 1'b1;
      end
      ST_OUT: begin
        if (bus.dump_ready) begin
          if (dump_last_q) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RD;
            addr_inc   = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered Moore outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_out      <= RST_ALL[NUM_RST-1:0];
      ins_en       <= 1'b0;
      dm_en        <= 1'b0;
      rd_en_q      <= 1'b0;
      dump_valid_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      rst_out      <= holds_reset(state_next) ? RST_ALL[NUM_RST-1:0] : RST_NONE[NUM_RST-1:0];
      ins_en       <= im_on(state_next);
      dm_en        <= dm_on(state_next);
      rd_en_q      <= (state_next == ST_RD);
      dump_valid_q <= (state_next == ST_OUT);
      busy         <= is_busy(state_next);
      done         <= (state_next == ST_DONE);
      if (to_clr)      timed_out <= 1'b0;
      else if (to_set) timed_out <= 1'b1;
    end
  end

  // Dump datapath: read address walks up to the last word and never wraps;
  // the captured word is held until the sink takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr     <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      dump_last_q <= 1'b0;
    end else begin
      if (addr_clr) begin
        rd_addr <= '0;
      end else if (addr_inc && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + DM_AW'(1);
      end
      if (cap_en) begin
        dump_data_q <= bus.dm_rd_data;
        dump_addr_q <= rd_addr;
        dump_last_q <= (rd_addr == LAST_ADDR);
      end
    end
  end

  assign bus.dm_rd_en   = rd_en_q;
  assign bus.dm_rd_addr = rd_addr;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_last  = dump_last_q;
  assign state_dbg      = state;

endmodule
